// File: rtl/obstacle_lane.sv
// obstacle_lane: scrolling lane of 7-segment obstacles for the runner game.
//
// The lane holds N_CELLS digit patterns (cell 0 sits next to the hero) and
// shifts them one cell toward the hero on every tick. The tick period shrinks
// as the speed level rises. Every RUN cycle the hero pattern is ANDed with
// cell 0. Any overlap ends the game as a loss. Obstacles that leave cell 0
// are counted as score, and reaching WIN_SCORE ends the game as a win.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        one-cycle pulse; (re)starts a game from IDLE, HIT or WIN
//   hero_seg     hero segment pattern (bit0=a .. bit6=g)
//   spawn_seg    ROM pattern for spawn_type, valid in the same cycle
//   spawn_type   ROM address, low TYPE_W bits of the LFSR
//   display_obs  cell i on bits [7i+6:7i]
//   tick         one-cycle pulse on every lane shift
//   status       00 idle/running, 01 lost, 10 won
//   score        cleared obstacle count
//   level        current speed level
//   fsm_state    raw FSM state (00 IDLE, 01 RUN, 10 HIT, 11 WIN) for debug
//
// Handshake: there are no valid/ready pairs. start is a single-cycle strobe
// sampled on the rising clock edge, and spawn_seg is a combinational reply to
// spawn_type within the same cycle.
module obstacle_lane #(
  parameter int          N_CELLS         = 3,
  parameter int          TYPE_W          = 5,
  parameter int          TICK_BASE       = 50000000,
  parameter int          TICK_STEP       = 5000000,
  parameter int          N_LEVELS        = 4,
  parameter int          SCORE_PER_LEVEL = 8,
  parameter int          WIN_SCORE       = 32,
  parameter int          MIN_GAP         = 1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [6:0]                                        hero_seg,
  input  logic [6:0]                                        spawn_seg,
  output logic [TYPE_W-1:0]                                 spawn_type,
  output logic [7*N_CELLS-1:0]                              display_obs,
  output logic                                              tick,
  output logic [1:0]                                        status,
  output logic [$clog2(WIN_SCORE+1)-1:0]                    score,
  output logic [((N_LEVELS > 1) ? $clog2(N_LEVELS) : 1)-1:0] level,
  output logic [1:0]                                        fsm_state
);

  localparam int SCORE_W = $clog2(WIN_SCORE + 1);
  localparam int LEVEL_W = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1;
  localparam int CNT_W   = $clog2(TICK_BASE + 1);
  localparam int GAP_W   = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HIT  = 2'd2;
  localparam logic [1:0] S_WIN  = 2'd3;

  logic [1:0]         state;
  logic [6:0]         cells [N_CELLS];
  logic [SCORE_W-1:0] score_q;
  logic [LEVEL_W-1:0] level_q;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period;   // period in use until the next wrap
  logic [GAP_W-1:0]   gap;
  logic [15:0]        lfsr;

  logic running;
  logic collide;
  logic won;
  logic wrap;
  logic spawn_ok;
  logic [15:0] lfsr_next;

  function automatic logic [CNT_W-1:0] period_for(input logic [LEVEL_W-1:0] lv);
    return CNT_W'(TICK_BASE - int'(lv) * TICK_STEP);
  endfunction

  function automatic logic [LEVEL_W-1:0] level_for(input logic [SCORE_W-1:0] s);
    int q;
    q = int'(s) / SCORE_PER_LEVEL;
    if (q > N_LEVELS - 1) q = N_LEVELS - 1;
    return LEVEL_W'(q);
  endfunction

  // Galois form: shift right, fold the taps back in when a 1 falls out.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  assign running  = (state == S_RUN);
  assign won      = running && (score_q == SCORE_W'(WIN_SCORE));
  assign collide  = running && ((cells[0] & hero_seg) != 7'd0);
  // A shift needs a live, unfinished, collision-free game at the end of a period.
  assign wrap     = running && !won && !collide && (cnt == period - CNT_W'(1));
  assign spawn_ok = lfsr[15] && (gap >= GAP_W'(MIN_GAP)) && (spawn_seg != 7'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      score_q <= '0;
      level_q <= '0;
      cnt     <= '0;
      period  <= CNT_W'(TICK_BASE);
      gap     <= GAP_W'(MIN_GAP);
      lfsr    <= LFSR_SEED;
      for (int i = 0; i < N_CELLS; i++) cells[i] <= 7'd0;
    end else begin
      lfsr <= lfsr_next;
      if (start && !running) begin
        state   <= S_RUN;
        score_q <= '0;
        level_q <= '0;
        cnt     <= '0;
        period  <= CNT_W'(TICK_BASE);
        gap     <= GAP_W'(MIN_GAP);
        for (int i = 0; i < N_CELLS; i++) cells[i] <= 7'd0;
      end else if (running) begin
        // Level trails score by one cycle.
        level_q <= level_for(score_q);
        if (won) begin
          state <= S_WIN;
        end else if (collide) begin
          state <= S_HIT;
        end else if (wrap) begin
          cnt    <= '0;
          // The new level only shortens the period from this wrap onward.
          period <= period_for(level_q);
          if (cells[0] != 7'd0) score_q <= score_q + SCORE_W'(1);
          for (int i = 0; i < N_CELLS - 1; i++) cells[i] <= cells[i+1];
          if (spawn_ok) begin
            cells[N_CELLS-1] <= spawn_seg;
            gap              <= '0;
          end else begin
            cells[N_CELLS-1] <= 7'd0;
            if (gap < GAP_W'(MIN_GAP)) gap <= gap + GAP_W'(1);
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    display_obs = '0;
    for (int i = 0; i < N_CELLS; i++) display_obs[7*i +: 7] = cells[i];
  end

  assign tick       = wrap;
  assign spawn_type = lfsr[TYPE_W-1:0];
  assign score      = score_q;
  assign level      = level_q;
  assign fsm_state  = state;
  assign status     = (state == S_HIT) ? 2'b01 :
                      (state == S_WIN) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_obstacle_lane.sv
// Testbench for obstacle_lane with a small, fast game configuration.
// A cycle model predicts every output; each expectation is queued before the
// clock edge and popped and compared just after it. Directed steps add
// explicit checks for the game scenarios.
module tb_obstacle_lane;

  localparam int NC  = 3;
  localparam int TW  = 5;
  localparam int TBS = 8;
  localparam int TST = 2;
  localparam int NL  = 3;
  localparam int SPL = 2;
  localparam int WS  = 6;
  localparam int MG  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  hero_seg;
  logic [6:0]  spawn_seg;
  logic [4:0]  spawn_type;
  logic [20:0] display_obs;
  logic        tick;
  logic [1:0]  status;
  logic [2:0]  score;
  logic [1:0]  level;
  logic [1:0]  fsm_state;

  obstacle_lane #(
    .N_CELLS(NC), .TYPE_W(TW), .TICK_BASE(TBS), .TICK_STEP(TST),
    .N_LEVELS(NL), .SCORE_PER_LEVEL(SPL), .WIN_SCORE(WS), .MIN_GAP(MG),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hero_seg(hero_seg),
    .spawn_seg(spawn_seg), .spawn_type(spawn_type), .display_obs(display_obs),
    .tick(tick), .status(status), .score(score), .level(level),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  int since_tick = 0;
  bit saw [0:15];

  // ---------------- model state ----------------
  int         m_st;      // 0 idle, 1 run, 2 hit, 3 win
  logic [6:0] m_cells [NC];
  int         m_score, m_level, m_cnt, m_period, m_gap;
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    if (v[0]) return (v >> 1) ^ 16'hB400;
    return v >> 1;
  endfunction

  function automatic logic [1:0] status_of(input int st);
    if (st == 2) return 2'b01;
    if (st == 3) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_out();
    logic coll, t;
    coll = (m_cells[0] & hero_seg) != 7'd0;
    t = (m_st == 1) && (m_score != WS) && !coll && (m_cnt == m_period - 1);
    return {m_cells[2], m_cells[1], m_cells[0], 3'(m_score), 2'(m_level),
            status_of(m_st), t, m_lfsr[4:0]};
  endfunction

  task automatic model_reset();
    m_st = 0; m_score = 0; m_level = 0; m_cnt = 0; m_period = TBS; m_gap = MG;
    m_lfsr = 16'hACE1;
    for (int i = 0; i < NC; i++) m_cells[i] = 7'd0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic coll;
    int lv;
    coll = (m_cells[0] & hero_seg) != 7'd0;
    if (start && m_st != 1) begin
      m_st = 1; m_score = 0; m_level = 0; m_cnt = 0; m_period = TBS; m_gap = MG;
      for (int i = 0; i < NC; i++) m_cells[i] = 7'd0;
    end else if (m_st == 1) begin
      lv = m_score / SPL;
      if (lv > NL - 1) lv = NL - 1;
      if (m_score == WS) m_st = 3;
      else if (coll) m_st = 2;
      else if (m_cnt == m_period - 1) begin
        m_cnt = 0;
        m_period = TBS - m_level * TST;
        if (m_cells[0] != 7'd0) m_score++;
        m_cells[0] = m_cells[1];
        m_cells[1] = m_cells[2];
        if (m_lfsr[15] && m_gap >= MG && spawn_seg != 7'd0) begin
          m_cells[2] = spawn_seg; m_gap = 0;
        end else begin
          m_cells[2] = 7'd0;
          if (m_gap < MG) m_gap++;
        end
      end else m_cnt++;
      m_level = lv;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  // One clock: queue the prediction, cross the edge, compare 1 time unit later.
  task automatic step();
    logic [33:0] e;
    logic adj;
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cycle_outputs", {display_obs, score, level, status, tick, spawn_type}, e);
    adj = ((display_obs[6:0] != 0) && (display_obs[13:7] != 0)) ||
          ((display_obs[13:7] != 0) && (display_obs[20:14] != 0));
    chk("no_adjacent_obstacles", adj, 1'b0);
    since_tick++;
    if (tick === 1'b1) begin
      if (since_tick < 16) saw[since_tick] = 1'b1;
      since_tick = 0;
    end
  endtask

  task automatic wait_tick(input string tag);
    for (int k = 0; k < 64 && tick !== 1'b1; k++) step();
    chk(tag, tick, 1'b1);
  endtask

  task automatic wait_cell0(input string tag);
    for (int k = 0; k < 800 && display_obs[6:0] == 7'd0; k++) step();
    chk(tag, display_obs[6:0], 7'h08);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [20:0] disp_s;
    logic [2:0]  score_s;
    int k;

    rst = 1'b1; start = 1'b0; hero_seg = 7'h01; spawn_seg = 7'h08;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_display", display_obs, 21'd0);
    chk("reset_score", score, 3'd0);
    chk("reset_level", level, 2'd0);
    chk("reset_status", status, 2'b00);
    chk("reset_tick", tick, 1'b0);
    chk("reset_spawn_type", spawn_type, 5'h01);
    chk("reset_state", fsm_state, 2'd0);
    rst = 1'b0;
    repeat (5) step();

    // Start with no obstacles: first tick after 8 RUN cycles, then every 8.
    spawn_seg = 7'h00;
    start = 1'b1; step(); start = 1'b0;
    chk("start_status", status, 2'b00);
    chk("start_state", fsm_state, 2'd1);
    k = 0;
    while (k < 20 && tick !== 1'b1) begin step(); k++; end
    chk("first_tick_latency", k, 7);
    step(); k = 1;
    while (k < 20 && tick !== 1'b1) begin step(); k++; end
    chk("tick_period_level0", k, 8);

    // Single obstacle traverses the lane and scores once.
    spawn_seg = 7'h08;
    for (k = 0; k < 800 && display_obs[20:14] == 7'd0; k++) step();
    chk("spawn_into_cell2", display_obs[20:14], 7'h08);
    wait_tick("tick_move1"); step();
    chk("obstacle_in_cell1", display_obs[13:7], 7'h08);
    wait_tick("tick_move2"); step();
    chk("obstacle_in_cell0", display_obs[6:0], 7'h08);
    wait_tick("tick_leave"); step();
    chk("cell0_after_leave", display_obs[6:0], 7'h00);
    chk("score_after_clear", score, 3'd1);

    // Collision in the same cycle as a tick: no shift, no score.
    wait_cell0("cell0_loaded_again");
    wait_tick("tick_with_cell0");
    disp_s = display_obs; score_s = score;
    hero_seg = 7'h08;
    step();
    chk("hit_tick_status", status, 2'b01);
    chk("hit_tick_display", display_obs, disp_s);
    chk("hit_tick_score", score, score_s);
    hero_seg = 7'h01;
    repeat (6) step();
    chk("hit_frozen_display", display_obs, disp_s);

    // start from HIT clears the game.
    start = 1'b1; step(); start = 1'b0;
    chk("restart_status", status, 2'b00);
    chk("restart_display", display_obs, 21'd0);
    chk("restart_score", score, 3'd0);
    chk("restart_level", level, 2'd0);

    // Collision right as an obstacle arrives in cell 0.
    wait_cell0("arrival_cell0");
    disp_s = display_obs; score_s = score;
    hero_seg = 7'h08;
    step();
    chk("arrival_hit_status", status, 2'b01);
    chk("arrival_hit_display", display_obs, disp_s);
    chk("arrival_hit_score", score, score_s);
    repeat (4) step();
    hero_seg = 7'h01;

    // start while running must not restart the tick counter.
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    chk("start_in_run_state", fsm_state, 2'd1);
    k = 0;
    while (k < 20 && tick !== 1'b1) begin step(); k++; end
    chk("start_in_run_ignored", k, 3);

    // Play to a win, recording tick spacing along the way.
    for (int i = 0; i < 16; i++) saw[i] = 1'b0;
    since_tick = 0;
    for (k = 0; k < 4000 && status !== 2'b10; k++) step();
    chk("win_status", status, 2'b10);
    chk("win_score", score, 3'd6);
    chk("win_level", level, 2'd2);
    chk("saw_period8", saw[8], 1'b1);
    chk("saw_period6", saw[6], 1'b1);
    chk("saw_period4", saw[4], 1'b1);
    disp_s = display_obs;
    repeat (10) step();
    chk("win_frozen_display", display_obs, disp_s);
    chk("win_frozen_score", score, 3'd6);

    // Asynchronous reset in the middle of a run with cells loaded.
    start = 1'b1; step(); start = 1'b0;
    for (k = 0; k < 800 && display_obs == 21'd0; k++) step();
    chk("cells_loaded_before_rst", display_obs != 21'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_display", display_obs, 21'd0);
    chk("midrst_score", score, 3'd0);
    chk("midrst_level", level, 2'd0);
    chk("midrst_status", status, 2'b00);
    chk("midrst_tick", tick, 1'b0);
    chk("midrst_spawn_type", spawn_type, 5'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 12; i++) begin step(); if (tick === 1'b1) k++; end
    chk("silent_after_rst", k, 0);
    spawn_seg = 7'h00;
    start = 1'b1; step(); start = 1'b0;
    k = 0;
    while (k < 20 && tick !== 1'b1) begin step(); k++; end
    step(); k = 1;
    while (k < 20 && tick !== 1'b1) begin step(); k++; end
    chk("tick_period_after_rst", k, 8);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
